// File: rtl/odyssey_pkg.sv
// -----------------------------------------------------------------------------
// odyssey_pkg
// Shared definitions for the core's memory-side blocks.
//   - arb_state_t : mem_arbiter FSM states (IDLE, ACCESS, RESP)
//   - REQ_INST / REQ_DATA : requester ids used by the arbiter and grant logic
//   - DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default bus widths
// -----------------------------------------------------------------------------
package odyssey_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
// Combinational two-way grant select between the fetch unit and the
// load/store unit.
//
// Configuration macro: MEM_ARBITER_RR_EN
//   defined   : round-robin; a one-bit last-winner pointer (reset = inst) makes
//               the requester not served last win a tie.
//   undefined : fixed priority, data beats inst; no pointer is built.
//
// Ports:
//   clk, rst      clock / synchronous active-high reset (pointer only)
//   i_inst_req    fetch request
//   i_data_req    load/store request
//   i_take        the arbiter is committing the current grant this cycle
//   o_grant       one-hot grant, bit 0 = inst, bit 1 = data; 0 when idle
//   o_winner      winner id (REQ_INST / REQ_DATA), meaningful when |o_grant
// -----------------------------------------------------------------------------
module mem_arb_grant
  import odyssey_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inst_req,
  input  logic       i_data_req,
  input  logic       i_take,
  output logic [1:0] o_grant,
  output logic       o_winner
);

  logic w_pick_data;

`ifdef MEM_ARBITER_RR_EN
  logic r_last;

  // Pointer only moves when a grant is actually taken, so a request that is
  // withdrawn before its grant does not disturb fairness.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= REQ_INST;
    end else if (i_take && (i_inst_req || i_data_req)) begin
      r_last <= o_winner;
    end
  end

  // A lone requester always wins; on a tie the one not served last wins.
  assign w_pick_data = i_data_req && (!i_inst_req || (r_last == REQ_INST));
`else
  logic w_unused;
  assign w_unused    = &{1'b0, clk, rst, i_take};
  assign w_pick_data = i_data_req;
`endif

  assign o_winner = w_pick_data ? REQ_DATA : REQ_INST;
  assign o_grant  = {w_pick_data, i_inst_req && !w_pick_data};

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the core's single memory port between the fetch unit (reads only)
// and the load/store unit (reads and writes). One transaction at a time is
// registered, presented to memory until acknowledged, and its result returned
// to the winner as a one-cycle valid pulse.
//
// Handshake: a requester raises *_req with stable fields and holds it until
// its *_valid pulse. The arbiter holds mem_req with stable fields until
// mem_ack; mem_rdata is taken in the same cycle as mem_ack. Requests are only
// sampled in IDLE, so a req still high in RESP becomes a new request in the
// following IDLE cycle.
//
// Configuration macro: MEM_ARBITER_RR_EN (round-robin tie break, see
// mem_arb_grant); default is fixed data-over-inst priority.
//
// Ports:
//   clk, rst                    clock / synchronous active-high reset
//   inst_req/inst_addr          fetch request
//   inst_valid/inst_data        fetch response pulse / read data (held)
//   data_req/we/addr/wdata/be   load/store request
//   data_valid/data_rdata       load/store response pulse / read data (held,
//                               0 after a write)
//   mem_req/we/addr/wdata/be    memory request (registered outputs)
//   mem_ack/mem_rdata           memory completion and read data
//   busy                        high whenever the FSM is not in IDLE
//   dbg_state                   current FSM state (arb_state_t encoding)
// -----------------------------------------------------------------------------
module mem_arbiter
  import odyssey_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic                    inst_valid,
  output logic [DATA_WIDTH-1:0]   inst_data,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  input  logic [DATA_WIDTH/8-1:0] data_be,
  output logic                    data_valid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  arb_state_t              r_state;
  arb_state_t              w_state_next;
  logic                    w_take;
  logic [1:0]              w_grant;
  logic                    w_winner;

  logic                    r_winner;
  logic                    r_mem_req;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_be;
  logic                    r_inst_valid;
  logic                    r_data_valid;
  logic [DATA_WIDTH-1:0]   r_inst_data;
  logic [DATA_WIDTH-1:0]   r_data_rdata;

  mem_arb_grant u_grant (
    .clk        (clk),
    .rst        (rst),
    .i_inst_req (inst_req),
    .i_data_req (data_req),
    .i_take     (w_take),
    .o_grant    (w_grant),
    .o_winner   (w_winner)
  );

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_state_next = ACCESS;
          w_take       = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ack) w_state_next = RESP;
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_winner     <= REQ_INST;
      r_mem_req    <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_inst_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_inst_data  <= '0;
      r_data_rdata <= '0;
    end else begin
      r_inst_valid <= 1'b0;
      r_data_valid <= 1'b0;

      if (w_take) begin
        r_winner  <= w_winner;
        r_mem_req <= 1'b1;
        if (w_winner == REQ_DATA) begin
          r_addr  <= data_addr;
          r_we    <= data_we;
          r_wdata <= data_wdata;
          r_be    <= data_be;
        end else begin
          r_addr  <= inst_addr;
          r_we    <= 1'b0;
          r_wdata <= '0;
          r_be    <= '1;
        end
      end

      // Completion: the valid pulse is registered here so it lands in RESP.
      if ((r_state == ACCESS) && mem_ack) begin
        r_mem_req <= 1'b0;
        if (r_winner == REQ_DATA) begin
          r_data_rdata <= r_we ? '0 : mem_rdata;
          r_data_valid <= 1'b1;
        end else begin
          r_inst_data  <= mem_rdata;
          r_inst_valid <= 1'b1;
        end
      end
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_be     = r_be;
  assign inst_valid = r_inst_valid;
  assign inst_data  = r_inst_data;
  assign data_valid = r_data_valid;
  assign data_rdata = r_data_rdata;
  assign busy       = (r_state != IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import odyssey_pkg::*;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_valid;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  // Scoreboard entries: {requester id, returned data}
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int inst_pulses = 0;
  int data_pulses = 0;
  int mem_delay   = 0;
  int wait_cnt    = 0;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_be    (data_be),
    .data_valid (data_valid),
    .data_rdata (data_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return a ^ 32'h8000_0013;
  endfunction

  // Memory responder: acks mem_delay cycles after mem_req is first seen.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt >= mem_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_model(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard: every valid pulse pops and compares one expected entry.
  always @(negedge clk) begin
    logic [32:0] got;
    logic [32:0] exp;
    if (inst_valid || data_valid) begin
      n_checks++;
      if (inst_valid && data_valid) begin
        $display("FAIL sb_both_valid: got inst_valid=1 data_valid=1 want only one");
      end else if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_valid: got inst_valid=%b data_valid=%b want none", inst_valid, data_valid);
      end else begin
        got = data_valid ? {REQ_DATA, data_rdata} : {REQ_INST, inst_data};
        exp = exp_q.pop_front();
        if (got !== exp)
          $display("FAIL sb_response: got id=%0d data=%h want id=%0d data=%h", got[32], got[31:0], exp[32], exp[31:0]);
        else
          n_pass++;
      end
    end
    if (inst_valid) inst_pulses++;
    if (data_valid) data_pulses++;
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive_edge();
    step();
    n_checks++; if ({mem_req, mem_we, inst_valid, data_valid, busy} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {mem_req, mem_we, inst_valid, data_valid, busy}); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 0", mem_addr, mem_wdata); else n_pass++;
    n_checks++; if (mem_be !== 4'h0) $display("FAIL reset_mem_be: got %h want 0", mem_be); else n_pass++;
    n_checks++; if (inst_data !== 32'h0 || data_rdata !== 32'h0) $display("FAIL reset_data_regs: got %h/%h want 0", inst_data, data_rdata); else n_pass++;
    n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
    drive_edge();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    drive_edge();
    inst_addr = 32'h8000_0000;
    inst_req  = 1'b1;
    exp_q.push_back({REQ_INST, 32'h0000_0013});
    step();  // cycle 0
    n_checks++; if (mem_req !== 1'b0) $display("FAIL fetch_c0_mem_req: got %b want 0", mem_req); else n_pass++;
    step();  // cycle 1
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) $display("FAIL fetch_c1_req_we: got req=%b we=%b want 1/0", mem_req, mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 32'h8000_0000) $display("FAIL fetch_c1_addr: got %h want 80000000", mem_addr); else n_pass++;
    n_checks++; if (mem_be !== 4'hF) $display("FAIL fetch_c1_be: got %h want f", mem_be); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL fetch_c1_busy: got %b want 1", busy); else n_pass++;
    step();  // cycle 2
    n_checks++; if (inst_valid !== 1'b1) $display("FAIL fetch_c2_valid: got %b want 1", inst_valid); else n_pass++;
    drive_edge();
    inst_req = 1'b0;
    step();  // cycle 3
    n_checks++; if (busy !== 1'b0 || inst_valid !== 1'b0) $display("FAIL fetch_c3_idle: got busy=%b valid=%b want 0/0", busy, inst_valid); else n_pass++;
  endtask

  task automatic test_priority();
    int start_inst;
    int start_total;
    drive_edge();
    inst_addr  = 32'h8000_0100;
    data_addr  = 32'h8000_2000;
    data_we    = 1'b0;
    data_be    = 4'hF;
    data_wdata = 32'h1234_5678;
`ifdef MEM_ARBITER_RR_EN
    exp_q.push_back({REQ_DATA, mem_model(32'h8000_2000)});
    exp_q.push_back({REQ_INST, mem_model(32'h8000_0100)});
    exp_q.push_back({REQ_DATA, mem_model(32'h8000_2000)});
    exp_q.push_back({REQ_INST, mem_model(32'h8000_0100)});
`else
    for (int i = 0; i < 4; i++) exp_q.push_back({REQ_DATA, mem_model(32'h8000_2000)});
`endif
    inst_req    = 1'b1;
    data_req    = 1'b1;
    start_inst  = inst_pulses;
    start_total = inst_pulses + data_pulses;
    for (int c = 0; c < 60 && (inst_pulses + data_pulses) < start_total + 4; c++) step();
    n_checks++; if ((inst_pulses + data_pulses) - start_total != 4) $display("FAIL prio_timeout: got %0d responses want 4", (inst_pulses + data_pulses) - start_total); else n_pass++;
    drive_edge();
    inst_req = 1'b0;
    data_req = 1'b0;
`ifdef MEM_ARBITER_RR_EN
    n_checks++; if (inst_pulses - start_inst != 2) $display("FAIL prio_inst_count: got %0d want 2", inst_pulses - start_inst); else n_pass++;
`else
    n_checks++; if (inst_pulses - start_inst != 0) $display("FAIL prio_inst_count: got %0d want 0", inst_pulses - start_inst); else n_pass++;
`endif
    repeat (4) step();
    n_checks++; if (exp_q.size() != 0) $display("FAIL prio_queue: got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_write();
    drive_edge();
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 32'h8000_1000;
    data_wdata = 32'hDEAD_BEEF;
    data_be    = 4'h3;
    exp_q.push_back({REQ_DATA, 32'h0});
    step();  // cycle 0
    step();  // cycle 1
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) $display("FAIL write_req_we: got req=%b we=%b want 1/1", mem_req, mem_we); else n_pass++;
    n_checks++; if (mem_addr !== 32'h8000_1000 || mem_wdata !== 32'hDEAD_BEEF) $display("FAIL write_fields: got addr=%h wdata=%h want 80001000/deadbeef", mem_addr, mem_wdata); else n_pass++;
    n_checks++; if (mem_be !== 4'h3) $display("FAIL write_be: got %h want 3", mem_be); else n_pass++;
    step();  // cycle 2
    n_checks++; if (data_valid !== 1'b1 || data_rdata !== 32'h0) $display("FAIL write_resp: got valid=%b rdata=%h want 1/0", data_valid, data_rdata); else n_pass++;
    drive_edge();
    data_req = 1'b0;
    data_we  = 1'b0;
  endtask

  task automatic test_wait_states();
    logic rise;
    logic stable_ok;
    int   lat;
    mem_delay = 5;
    drive_edge();
    inst_addr = 32'h8000_0200;
    inst_req  = 1'b1;
    exp_q.push_back({REQ_INST, mem_model(32'h8000_0200)});
    rise = 1'b0;
    for (int c = 0; c < 10 && !rise; c++) begin
      step();
      if (mem_req === 1'b1) rise = 1'b1;
    end
    n_checks++; if (rise !== 1'b1) $display("FAIL wait_req_rise: got %b want 1", rise); else n_pass++;
    lat = 0;
    stable_ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (inst_valid === 1'b1) begin
        lat = c;
        break;
      end
      if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0200) stable_ok = 1'b0;
    end
    n_checks++; if (stable_ok !== 1'b1) $display("FAIL wait_stable: got %b want 1", stable_ok); else n_pass++;
    n_checks++; if (lat != 6) $display("FAIL wait_latency: got %0d want 6", lat); else n_pass++;
    drive_edge();
    inst_req  = 1'b0;
    mem_delay = 0;
  endtask

  task automatic test_reset_mid_access();
    int p0;
    int pi;
    mem_delay = 20;
    drive_edge();
    inst_addr = 32'h8000_0300;
    inst_req  = 1'b1;
    for (int c = 0; c < 10 && mem_req !== 1'b1; c++) step();
    drive_edge();  // second ACCESS cycle
    rst      = 1'b1;
    inst_req = 1'b0;
    p0 = inst_pulses + data_pulses;
    step();
    step();
    n_checks++; if (mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_outputs: got req=%b busy=%b want 0/0", mem_req, busy); else n_pass++;
    drive_edge();
    rst = 1'b0;
    repeat (4) step();
    n_checks++; if (inst_pulses + data_pulses != p0) $display("FAIL rst_mid_no_valid: got %0d pulses want 0", inst_pulses + data_pulses - p0); else n_pass++;
    mem_delay = 0;
    drive_edge();
    inst_addr = 32'h8000_0304;
    inst_req  = 1'b1;
    exp_q.push_back({REQ_INST, mem_model(32'h8000_0304)});
    pi = inst_pulses;
    for (int c = 0; c < 20 && inst_pulses == pi; c++) step();
    n_checks++; if (inst_pulses != pi + 1) $display("FAIL rst_mid_recover: got %0d pulses want 1", inst_pulses - pi); else n_pass++;
    drive_edge();
    inst_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int p0;
    int t;
    drive_edge();
    inst_addr = 32'h8000_0000;
    inst_req  = 1'b1;
    exp_q.push_back({REQ_INST, 32'h0000_0013});
    p0 = inst_pulses;
    for (int c = 0; c < 20 && inst_pulses == p0; c++) step();
    n_checks++; if (inst_pulses != p0 + 1) $display("FAIL b2b_first: got %0d pulses want 1", inst_pulses - p0); else n_pass++;
    // Still in RESP: keep req high and move to the next word.
    inst_addr = 32'h8000_0004;
    exp_q.push_back({REQ_INST, 32'h0000_0017});
    t = 0;
    for (int c = 0; c < 20 && inst_pulses == p0 + 1; c++) begin
      step();
      t++;
    end
    n_checks++; if (inst_pulses != p0 + 2 || t != 3) $display("FAIL b2b_second: got pulses=%0d gap=%0d want 2/3", inst_pulses - p0, t); else n_pass++;
    drive_edge();
    inst_req = 1'b0;
    repeat (5) step();
    n_checks++; if (inst_pulses != p0 + 2) $display("FAIL b2b_no_dup: got %0d pulses want 2", inst_pulses - p0); else n_pass++;
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    rst        = 1'b1;
    inst_req   = 1'b0;
    inst_addr  = '0;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = '0;
    data_wdata = '0;
    data_be    = '0;

    test_reset();
    test_single_fetch();
    test_priority();
    test_write();
    test_wait_states();
    test_reset_mid_access();
    test_back_to_back();

    repeat (3) step();
    n_checks++; if (exp_q.size() != 0) $display("FAIL final_queue: got %0d pending want 0", exp_q.size()); else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the core's single memory port between the fetch unit (instruction reads) and the load/store unit (data reads/writes). It sits between both requesters and the memory/cache interface. Each transaction is registered, driven to memory until acknowledged, and the result is returned to the winning requester as a one-cycle valid pulse. It serialises one transaction at a time and guarantees that no request is dropped.

## Interface
- DATA_WIDTH, 32, data bus width; must be a multiple of 8
- ADDR_WIDTH, 32, address width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- inst_req  in  1  fetch read request; held until inst_valid
- inst_addr  in  ADDR_WIDTH  fetch address; stable while inst_req
- inst_valid  out  1  one-cycle pulse, inst_data valid
- inst_data  out  DATA_WIDTH  read data for fetch
- data_req  in  1  load/store request; held until data_valid
- data_we  in  1  1 = write, 0 = read
- data_addr  in  ADDR_WIDTH  load/store address
- data_wdata  in  DATA_WIDTH  write data
- data_be  in  DATA_WIDTH/8  byte enables
- data_valid  out  1  one-cycle pulse, transaction complete
- data_rdata  out  DATA_WIDTH  read data; 0 on write completion
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables; all ones for fetch
- mem_ack  in  1  memory accepts/completes; mem_rdata valid same cycle
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any request is present, select a winner and register its address, we, wdata and be (fetch: we=0, be=all ones). Record the winner id, then go to ACCESS. With no request, stay in IDLE.
- Default priority is fixed: data beats inst on simultaneous requests.
- ACCESS: mem_req=1 with the registered fields. On mem_ack, capture mem_rdata (forced to 0 for writes) into the winner's data register, then go to RESP. Without ack, remain in ACCESS indefinitely with all fields stable.
- RESP: pulse the winner's valid for exactly one cycle, then go to IDLE. Requests are not sampled in RESP. A req still high in RESP is treated as a new request in the following IDLE cycle.
- The losing requester keeps its req high and is served in a later IDLE cycle. Its valid stays 0 until then.
- inst_data/data_rdata hold their last value between pulses.
- A requester that deasserts req before its grant is simply not served. Deassertion after grant does not abort the transaction.
- Reset values: all outputs 0, state IDLE, data registers 0, winner id = inst.
- Reset during ACCESS drops mem_req on the next cycle and abandons the transaction; no valid is issued.

## Timing
- Minimum latency: req sampled in cycle 0 (IDLE) -> mem_req in cycle 1 -> mem_ack in cycle 1 -> valid in cycle 2.
- Each additional wait cycle without mem_ack adds one cycle.
- Maximum throughput: one transaction per 3 cycles.
- mem_* outputs and valid outputs are driven directly from registers, with no combinational path from req or mem_ack.
- Simultaneous inst_req and data_req in IDLE: exactly one winner per arbitration cycle.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin arbitration. A one-bit last-winner register (reset = inst, so data wins the first tie) makes the requester not served last win on simultaneous requests. A single requester is always granted regardless of the pointer. Neither requester waits more than one other transaction.
- MEM_ARBITER_RR_EN undefined: fixed data-over-inst priority, and the pointer logic is not compiled. Fetch may starve under continuous data traffic; this is accepted.

## Structure
- The shared package odyssey_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - requester id constants (REQ_INST=0, REQ_DATA=1);
  - the reset values of the default width parameters.
- Sub-module mem_arb_grant: combinational 2-way grant select, plus the round-robin pointer under MEM_ARBITER_RR_EN. It outputs a one-hot grant and the winner id.
- The FSM and datapath registers live in mem_arbiter.

## Test plan
- Single fetch: inst_req=1, inst_addr=0x80000000, memory acks in cycle 1 with 0x00000013 -> mem_addr=0x80000000, mem_be=0xF, inst_valid pulses in cycle 2 with inst_data=0x00000013, busy back to 0 in cycle 3.
- Write: data_req=1, data_we=1, data_addr=0x80001000, data_wdata=0xDEADBEEF, data_be=0x3 -> mem_we=1 with matching fields, data_valid pulse, data_rdata=0.
- Simultaneous requests, fixed priority: both held for 4 transactions with ack in 1 cycle -> data served every time and inst_valid never asserts; with MEM_ARBITER_RR_EN the grants alternate data, inst, data, inst.
- Wait states: mem_ack delayed 5 cycles -> mem_req and mem_addr stable throughout, valid 6 cycles after the mem_req rise.
- Reset mid-ACCESS: rst asserted in the second cycle of ACCESS -> mem_req=0, busy=0, no valid pulse. A fresh inst_req afterwards completes normally.
- Back-to-back fetch: inst_req held high through RESP with inst_addr changed to 0x80000004 -> the second transaction starts in the next IDLE cycle at 0x80000004, and there is no duplicate valid pulse.
